// File: rtl/a_cntr_pkg.sv
// Shared definitions for the counter family (up and down counters).
// Holds default sizing, the prescaler width helper and the default count type.
package a_cntr_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_MOD   = 16;
    localparam int unsigned DEF_DIV   = 1;

    // Prescaler register width: clog2(div), never narrower than one bit.
    function automatic int unsigned pre_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

    typedef logic [DEF_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/a_up_cntr_if.sv
// Control/status bundle of the modulo-N up counter.
// master: drives en, load, load_val, clr_ovf; observes count, tc, carry, ovf.
// slave : the counter side of the same signals.
interface a_up_cntr_if #(
    parameter int unsigned WIDTH = a_cntr_pkg::DEF_WIDTH
) ();

    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             carry;
    logic             ovf;

    modport master (
        output en, load, load_val, clr_ovf,
        input  count, tc, carry, ovf
    );

    modport slave (
        input  en, load, load_val, clr_ovf,
        output count, tc, carry, ovf
    );

endinterface

// File: rtl/a_cntr_prescale.sv
// Clock-enable prescaler: issues one tick per DIV enabled cycles.
// Ports: clk, rst (sync, active-high), en (advance), clr (restart period),
//        tick (en & last prescale state; combinational from pre register).
module a_cntr_prescale
    import a_cntr_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW      = pre_width(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    logic [PW-1:0] pre;

    // With DIV=1 pre stays at 0 == PRE_MAX, so tick degenerates to en.
    assign tick = en & (pre == PRE_MAX);

    // Phase counter: frozen while en is low, restarted by clr.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else if (en) begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/a_up_cntr.sv
// Synchronous modulo-MOD up counter with enable, parallel load, prescaler,
// terminal-count flag, registered carry pulse and sticky overflow.
// Ports: clk, rst (sync, active-high), bus (a_up_cntr_if.slave):
//   en, load, load_val, clr_ovf in; count, tc (combinational), carry, ovf out.
// Optional macro A_UP_CNTR_SAT_EN: saturate at MOD-1 instead of wrapping
// (carry never asserts, ovf sets on the first tick attempted at MOD-1).
module a_up_cntr
    import a_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned MOD   = DEF_MOD,
    parameter int unsigned DIV   = DEF_DIV
) (
    input  logic         clk,
    input  logic         rst,
    a_up_cntr_if.slave   bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);

    logic             tick;
    logic             at_max;
    logic             wrap;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             ovf;

    a_cntr_prescale #(
        .DIV (DIV)
    ) u_prescale (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.load),
        .tick (tick)
    );

    assign at_max = (count == CNT_MAX);
    // A tick at MOD-1 that is not overridden by load (wrap or held step).
    assign wrap   = tick & ~bus.load & at_max;

    // Count and carry: load beats step; carry only lives for the wrap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            carry <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (bus.load) begin
                count <= (bus.load_val > CNT_MAX) ? CNT_MAX : bus.load_val;
            end else if (tick) begin
                if (at_max) begin
`ifdef A_UP_CNTR_SAT_EN
                    count <= CNT_MAX;
`else
                    count <= '0;
                    carry <= 1'b1;
`endif
                end else begin
                    count <= count + WIDTH'(1);
                end
            end
        end
    end

    // Sticky overflow: a wrap on the same edge as clr_ovf keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wrap) begin
            ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    assign bus.count = count;
    assign bus.tc    = at_max;
    assign bus.carry = carry;
    assign bus.ovf   = ovf;

endmodule

// File: tb/tb_a_up_cntr.sv
// Self-checking bench for a_up_cntr: two instances (DIV=1 and DIV=3, MOD=10)
// share one stimulus stream; a cycle model checks every output each cycle and
// directed literal checks pin the expected behaviour.
module tb_a_up_cntr;
    import a_cntr_pkg::*;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
`ifdef A_UP_CNTR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, en, load, clr_ovf;
    cnt_t load_val;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    a_up_cntr_if #(.WIDTH(WIDTH)) if1 ();
    a_up_cntr_if #(.WIDTH(WIDTH)) if3 ();

    assign if1.en = en;  assign if1.load = load;  assign if1.load_val = load_val;  assign if1.clr_ovf = clr_ovf;
    assign if3.en = en;  assign if3.load = load;  assign if3.load_val = load_val;  assign if3.clr_ovf = clr_ovf;

    a_up_cntr #(.WIDTH(WIDTH), .MOD(MOD), .DIV(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    a_up_cntr #(.WIDTH(WIDTH), .MOD(MOD), .DIV(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt   [2];
    int m_sub   [2];   // enabled cycles since the last step
    int m_carry [2];
    int m_ovf   [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit wrapped;
            wrapped = 1'b0;
            if (rst) begin
                m_cnt[i] = 0; m_sub[i] = 0; m_carry[i] = 0; m_ovf[i] = 0;
            end else if (load) begin
                m_cnt[i]   = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
                m_sub[i]   = 0;
                m_carry[i] = 0;
                if (clr_ovf) m_ovf[i] = 0;
            end else begin
                m_carry[i] = 0;
                if (en) begin
                    m_sub[i]++;
                    if (m_sub[i] == div_of(i)) begin
                        m_sub[i] = 0;
                        if (m_cnt[i] == MOD - 1) begin
                            wrapped  = 1'b1;
                            m_ovf[i] = 1;
                            if (!SAT) begin
                                m_cnt[i]   = 0;
                                m_carry[i] = 1;
                            end
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                end
                if (!wrapped && clr_ovf) m_ovf[i] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of both instances against the model.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("u1.count", int'(if1.count), m_cnt[0]);
            chk("u1.tc",    int'(if1.tc),    int'(m_cnt[0] == MOD - 1));
            chk("u1.carry", int'(if1.carry), m_carry[0]);
            chk("u1.ovf",   int'(if1.ovf),   m_ovf[0]);
            chk("u3.count", int'(if3.count), m_cnt[1]);
            chk("u3.tc",    int'(if3.tc),    int'(m_cnt[1] == MOD - 1));
            chk("u3.carry", int'(if3.carry), m_carry[1]);
            chk("u3.ovf",   int'(if3.ovf),   m_ovf[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int carries;
        int exp_wrap_cnt;
        int exp_end25;
        int exp_carries25;
        int exp_hold;
        int exp_hold_carries;
        int exp_flag_cnt;
        exp_wrap_cnt     = SAT ? 9 : 0;
        exp_end25        = SAT ? 9 : 5;
        exp_carries25    = SAT ? 0 : 2;
        exp_hold         = SAT ? 9 : 4;
        exp_hold_carries = SAT ? 0 : 1;
        exp_flag_cnt     = SAT ? 9 : 0;

        rst = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; clr_ovf = 1'b0;
        cyc(1);
        chk_on = 1'b1;
        cyc(1);
        chk("rst.count", int'(if1.count), 0);
        chk("rst.tc",    int'(if1.tc),    0);
        chk("rst.carry", int'(if1.carry), 0);
        chk("rst.ovf",   int'(if1.ovf),   0);

        // Free run for 25 enabled cycles.
        rst = 1'b0; en = 1'b1; carries = 0;
        for (int k = 1; k <= 25; k++) begin
            cyc(1);
            if (if1.carry) carries++;
            if (k == 9) begin
                chk("run.count9", int'(if1.count), 9);
                chk("run.tc9",    int'(if1.tc),    1);
            end
            if (k == 10) begin
                chk("run.wrap_count", int'(if1.count), exp_wrap_cnt);
                chk("run.wrap_carry", int'(if1.carry), SAT ? 0 : 1);
                chk("run.wrap_ovf",   int'(if1.ovf),   1);
            end
        end
        chk("run.end_count",  int'(if1.count), exp_end25);
        chk("run.carries",    carries,         exp_carries25);
        chk("run.div3_count", int'(if3.count), 8);

        // Load 7 while enabled, then reset mid-count.
        load_val = 4'd7; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("ld7.count", int'(if1.count), 7);
        chk("ld7.ovf",   int'(if1.ovf),   1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst7.count", int'(if1.count), 0);
        chk("rst7.carry", int'(if1.carry), 0);
        chk("rst7.ovf",   int'(if1.ovf),   0);

        // DIV=3: freeze across 4 disabled cycles, then resume.
        cyc(4);
        chk("frz.pre", int'(if3.count), 1);
        en = 1'b0;
        cyc(4);
        chk("frz.hold", int'(if3.count), 1);
        en = 1'b1;
        cyc(1);
        chk("frz.res1", int'(if3.count), 1);
        cyc(1);
        chk("frz.res2", int'(if3.count), 2);

        // Load cases.
        en = 1'b0; load_val = 4'd6; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("ld6.count", int'(if1.count), 6);
        en = 1'b1;
        cyc(1);
        chk("ld6.step", int'(if1.count), 7);
        load_val = 4'd12; load = 1'b1;
        cyc(1);
        chk("ld12.count", int'(if1.count), 9);
        chk("ld12.tc",    int'(if1.tc),    1);
        chk("ld12.div3",  int'(if3.count), 9);
        load_val = 4'd2;
        cyc(1);
        load = 1'b0; en = 1'b0;
        chk("ldwrap.count", int'(if1.count), 2);
        chk("ldwrap.carry", int'(if1.carry), 0);
        chk("ldwrap.ovf",   int'(if1.ovf),   0);

        // clr_ovf coinciding with a wrap, then alone.
        load_val = 4'd9; load = 1'b1;
        cyc(1);
        load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
        cyc(1);
        chk("clrwrap.ovf",   int'(if1.ovf),   1);
        chk("clrwrap.count", int'(if1.count), exp_flag_cnt);
        en = 1'b0;
        cyc(1);
        clr_ovf = 1'b0;
        chk("clr.ovf", int'(if1.ovf), 0);

        // Five ticks starting at MOD-1 (held in saturating mode).
        load_val = 4'd9; load = 1'b1;
        cyc(1);
        load = 1'b0; en = 1'b1; carries = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            if (if1.carry) carries++;
            if (k == 1) chk("hold.ovf1", int'(if1.ovf), 1);
        end
        chk("hold.count",   int'(if1.count), exp_hold);
        chk("hold.carries", carries,         exp_hold_carries);
        en = 1'b0; load_val = 4'd3; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("ld3.count", int'(if1.count), 3);
        en = 1'b1;
        cyc(1);
        chk("ld3.step", int'(if1.count), 4);
        en = 1'b0;
        cyc(2);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
